sram_access_ctrl: RTL and testbench

//  Owns the 256x32b feature SRAM (byte-masked write port, 1-cycle registered read port).

---
 rtl/sram_access_ctrl_pkg.sv | 25 ++
 rtl/sram_access_ctrl_if.sv | 28 ++
 rtl/sram_access_ctrl_rr_arb2.sv | 26 ++
 rtl/sram_access_ctrl.sv | 122 ++++++++++++
 tb/tb_sram_access_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_access_ctrl_pkg.sv
// Shared types and constants for the feature-SRAM access controller.
// Write FSM states, the clear-mask encoding and a lowest-set-bit helper.
package sram_ctrl_pkg;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 256;
  localparam int NRD    = 2;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_BYTE = 2'd1,
    W_CLR  = 2'd2
  } w_state_t;

  localparam logic [3:0] BMASK_CLR = 4'b0000;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [1:0] lowest_set(input logic [3:0] m);
    lowest_set = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (m[k]) lowest_set = k[1:0];
    end
  endfunction

endpackage

// File: rtl/sram_access_ctrl_if.sv
// Client-side bus of the SRAM access controller: one word writer, NRD readers.
// Handshakes: a write transfers on wr_valid & wr_ready; a read request stays on
// rd_valid[i] until rd_gnt[i], and its data is on rd_rdata while rd_rvalid[i] is high.
interface sram_access_ctrl_if;
  import sram_ctrl_pkg::*;

  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_W-1:0]     wr_addr;
  logic [31:0]           wr_data;
  logic [3:0]            wr_bmask;
  logic [NRD-1:0]        rd_valid;
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD-1:0]        rd_gnt;
  logic [NRD-1:0]        rd_rvalid;
  logic [31:0]           rd_rdata;

  modport master (
    output wr_valid, wr_addr, wr_data, wr_bmask, rd_valid, rd_addr,
    input  wr_ready, rd_gnt, rd_rvalid, rd_rdata
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_bmask, rd_valid, rd_addr,
    output wr_ready, rd_gnt, rd_rvalid, rd_rdata
  );

endinterface

// File: rtl/sram_access_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter: combinational one-hot grant, registered
// record of the last winner so a tie goes to the other client.
module rr_arb2 (
  input  logic       clk,
  input  logic       srst,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       rr_last
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = rr_last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst)      rr_last <= 1'b1;
    else if (|gnt) rr_last <= gnt[1];
  end

endmodule

// File: rtl/sram_access_ctrl.sv
// Feature-SRAM owner: splits word writes into single-byte SRAM writes (or one
// clear cycle) and round-robins two readers with a per-address RAW block.
module sram_access_ctrl
  import sram_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               srst,
  sram_access_ctrl_if.slave  bus,
  output logic               sram_csb,
  output logic               sram_wsb,
  output logic [3:0]         sram_bytemask,
  output logic [7:0]         sram_wdata,
  output logic [ADDR_W-1:0]  sram_waddr,
  output logic [ADDR_W-1:0]  sram_raddr,
  input  logic [31:0]        sram_rdata,
  output w_state_t           wr_state,
  output logic               rr_last
);

  w_state_t          state, state_nxt;
  logic [ADDR_W-1:0] cap_addr;
  logic [31:0]       cap_data;
  logic [3:0]        rem_mask;
  logic [7:0]        wdata_hold;
  logic              accept;
  logic              wr_busy;
  logic [1:0]        lane;
  logic [3:0]        lane_onehot;
  logic [7:0]        lane_byte;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [1:0]        eligible;
  logic [1:0]        gnt;

  assign accept      = bus.wr_valid & bus.wr_ready;
  // srst gates the write strobes so a reset cycle never lands another byte.
  assign wr_busy     = (state != W_IDLE) & ~srst;
  assign lane        = lowest_set(rem_mask);
  assign lane_onehot = 4'b0001 << lane;
  assign lane_byte   = cap_data[{lane, 3'b000} +: 8];

  always_ff @(posedge clk) begin
    if (srst) state <= W_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      W_IDLE:  if (accept) state_nxt = (bus.wr_bmask == BMASK_CLR) ? W_CLR : W_BYTE;
      W_BYTE:  if ((rem_mask & ~lane_onehot) == 4'b0000) state_nxt = W_IDLE;
      W_CLR:   state_nxt = W_IDLE;
      default: state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    bus.wr_ready  = 1'b0;
    sram_wsb      = 1'b1;
    sram_bytemask = 4'b0000;
    sram_wdata    = wdata_hold;
    if (!srst) begin
      case (state)
        W_IDLE: bus.wr_ready = 1'b1;
        W_BYTE: begin
          sram_wsb      = 1'b0;
          sram_bytemask = lane_onehot;
          sram_wdata    = lane_byte;
        end
        W_CLR: begin
          sram_wsb      = 1'b0;
          sram_bytemask = BMASK_CLR;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      cap_addr   <= '0;
      cap_data   <= '0;
      rem_mask   <= '0;
      wdata_hold <= '0;
    end else if (accept) begin
      cap_addr <= bus.wr_addr;
      cap_data <= bus.wr_data;
      rem_mask <= bus.wr_bmask;
    end else if (state == W_BYTE) begin
      rem_mask   <= rem_mask & ~lane_onehot;
      wdata_hold <= lane_byte;
    end
  end

  assign addr0 = bus.rd_addr[0 +: ADDR_W];
  assign addr1 = bus.rd_addr[ADDR_W +: ADDR_W];

  // A read of the word being written waits until the write is complete.
  assign eligible[0] = bus.rd_valid[0] & ~srst & ~(wr_busy & (addr0 == cap_addr));
  assign eligible[1] = bus.rd_valid[1] & ~srst & ~(wr_busy & (addr1 == cap_addr));

  rr_arb2 u_arb (
    .clk     (clk),
    .srst    (srst),
    .req     (eligible),
    .gnt     (gnt),
    .rr_last (rr_last)
  );

  assign bus.rd_gnt = gnt;

  always_ff @(posedge clk) begin
    if (srst) bus.rd_rvalid <= '0;
    else      bus.rd_rvalid <= gnt;
  end

  assign bus.rd_rdata = sram_rdata;
  assign sram_raddr   = gnt[1] ? addr1 : (gnt[0] ? addr0 : '0);
  assign sram_waddr   = cap_addr;
  assign sram_csb     = ~((|gnt) | wr_busy);
  assign wr_state     = state;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: behavioural SRAM, arbitration vector table,
// directed write/hazard/reset sequences and a randomized model-checked phase.
module tb_sram_access_ctrl;
  import sram_ctrl_pkg::*;

  logic              clk = 1'b0;
  logic              srst;
  logic              sram_csb, sram_wsb;
  logic [3:0]        sram_bytemask;
  logic [7:0]        sram_wdata;
  logic [ADDR_W-1:0] sram_waddr, sram_raddr;
  logic [31:0]       sram_rdata;
  w_state_t          wr_state;
  logic              rr_last;

  sram_access_ctrl_if bus ();

  sram_access_ctrl dut (
    .clk           (clk),
    .srst          (srst),
    .bus           (bus),
    .sram_csb      (sram_csb),
    .sram_wsb      (sram_wsb),
    .sram_bytemask (sram_bytemask),
    .sram_wdata    (sram_wdata),
    .sram_waddr    (sram_waddr),
    .sram_raddr    (sram_raddr),
    .sram_rdata    (sram_rdata),
    .wr_state      (wr_state),
    .rr_last       (rr_last)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem    [0:DEPTH-1];
  logic [31:0] golden [0:DEPTH-1];
  logic [31:0] exp_q  [$];

  function automatic logic [31:0] init_word(input int i);
    return 32'h9E3779B9 * (i + 1);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] m);
    logic [31:0] r;
    if (m == 4'b0000) return 32'h0;
    r = old;
    for (int k = 0; k < 4; k++) if (m[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural SRAM: registered read of pre-write data, one-hot byte or clear write.
  always @(posedge clk) begin
    if (!sram_csb) begin
      sram_rdata <= mem[sram_raddr[7:0]];
      if (!sram_wsb) begin
        n_checks++;
        if (!(sram_bytemask inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h8})) begin
          n_fail++;
          $display("FAIL bytemask_onehot: got %h expected one-hot or 0", sram_bytemask);
        end
        if (sram_bytemask inside {4'h1, 4'h2, 4'h4, 4'h8}) begin
          for (int k = 0; k < 4; k++)
            if (sram_bytemask[k]) mem[sram_waddr[7:0]][8*k +: 8] <= sram_wdata;
        end else begin
          mem[sram_waddr[7:0]] <= 32'h0;
        end
      end
    end
  end

  task automatic drive_idle();
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.wr_bmask = '0;
    bus.rd_valid = '0;
    bus.rd_addr  = '0;
  endtask

  task automatic check_reset_values();
    chk("rst_wr_ready", {31'b0, bus.wr_ready}, 1);
    chk("rst_csb", {31'b0, sram_csb}, 1);
    chk("rst_wsb", {31'b0, sram_wsb}, 1);
    chk("rst_bytemask", {28'b0, sram_bytemask}, 0);
    chk("rst_wdata", {24'b0, sram_wdata}, 0);
    chk("rst_waddr", {22'b0, sram_waddr}, 0);
    chk("rst_raddr", {22'b0, sram_raddr}, 0);
    chk("rst_rvalid", {30'b0, bus.rd_rvalid}, 0);
    chk("rst_state", {30'b0, wr_state}, 0);
  endtask

  // Starts and ends at a negedge; checks each byte strobe and the ready gap.
  task automatic do_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] m);
    logic [3:0] lane_mask;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    bus.wr_bmask = m;
    #2 chk("wr_ready_accept", {31'b0, bus.wr_ready}, 1);
    @(negedge clk);
    bus.wr_valid = 1'b0;
    if (m == 4'b0000) begin
      #2;
      chk("clr_wsb", {31'b0, sram_wsb}, 0);
      chk("clr_bytemask", {28'b0, sram_bytemask}, 0);
      chk("clr_waddr", {22'b0, sram_waddr}, {22'b0, a});
      chk("clr_ready", {31'b0, bus.wr_ready}, 0);
      @(negedge clk);
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (m[k]) begin
          lane_mask = 4'b0001 << k;
          #2;
          chk("byte_wsb", {31'b0, sram_wsb}, 0);
          chk("byte_mask", {28'b0, sram_bytemask}, {28'b0, lane_mask});
          chk("byte_wdata", {24'b0, sram_wdata}, {24'b0, d[8*k +: 8]});
          chk("byte_waddr", {22'b0, sram_waddr}, {22'b0, a});
          chk("byte_ready", {31'b0, bus.wr_ready}, 0);
          @(negedge clk);
        end
      end
    end
    #2;
    chk("wr_ready_after", {31'b0, bus.wr_ready}, 1);
    chk("wsb_after", {31'b0, sram_wsb}, 1);
    @(negedge clk);
  endtask

  typedef struct {
    logic [1:0] v;
    logic [9:0] a0;
    logic [9:0] a1;
    logic [1:0] g;
    logic [9:0] ra;
  } arb_vec_t;

  arb_vec_t tbl [10];

  initial begin
    logic [1:0]  prev_g;
    logic [9:0]  prev_ra;
    logic        w_pend;
    logic [9:0]  w_addr;
    logic [31:0] w_data;
    logic [3:0]  w_mask;
    logic [1:0]  r_pend;
    logic [9:0]  r_addr [2];
    int          busy_left;
    logic [9:0]  b_addr;
    logic [31:0] b_data;
    logic [3:0]  b_mask;
    int          m_last;
    logic [1:0]  elig, exp_g;
    logic        exp_ready;
    logic [31:0] exp_d;
    int          cyc;
    int          idx;

    for (int i = 0; i < DEPTH; i++) begin
      mem[i]    = init_word(i);
      golden[i] = init_word(i);
    end
    sram_rdata = 32'h0;
    drive_idle();
    srst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    srst = 1'b0;
    #2 check_reset_values();
    @(negedge clk);

    // Arbitration vectors, no writes; rr_last starts at 1 so client 0 wins the first tie.
    tbl[0] = '{2'b11, 10'd3,  10'd4,  2'b01, 10'd3};
    tbl[1] = '{2'b11, 10'd3,  10'd4,  2'b10, 10'd4};
    tbl[2] = '{2'b01, 10'd1,  10'd2,  2'b01, 10'd1};
    tbl[3] = '{2'b01, 10'd6,  10'd2,  2'b01, 10'd6};
    tbl[4] = '{2'b11, 10'd5,  10'd9,  2'b10, 10'd9};
    tbl[5] = '{2'b10, 10'd0,  10'd10, 2'b10, 10'd10};
    tbl[6] = '{2'b11, 10'd12, 10'd13, 2'b01, 10'd12};
    tbl[7] = '{2'b00, 10'd2,  10'd3,  2'b00, 10'd0};
    tbl[8] = '{2'b11, 10'd14, 10'd15, 2'b10, 10'd15};
    tbl[9] = '{2'b00, 10'd1,  10'd1,  2'b00, 10'd0};
    prev_g  = 2'b00;
    prev_ra = '0;
    for (int t = 0; t < 10; t++) begin
      bus.rd_valid = tbl[t].v;
      bus.rd_addr  = {tbl[t].a1, tbl[t].a0};
      #2;
      chk("tbl_gnt", {30'b0, bus.rd_gnt}, {30'b0, tbl[t].g});
      chk("tbl_raddr", {22'b0, sram_raddr}, {22'b0, tbl[t].ra});
      chk("tbl_csb", {31'b0, sram_csb}, {31'b0, tbl[t].g == 2'b00});
      chk("tbl_rvalid", {30'b0, bus.rd_rvalid}, {30'b0, prev_g});
      if (prev_g != 2'b00) chk("tbl_rdata", bus.rd_rdata, golden[prev_ra]);
      prev_g  = tbl[t].g;
      prev_ra = tbl[t].ra;
      @(negedge clk);
    end
    drive_idle();

    do_write(10'd5, 32'hA1B2C3D4, 4'hF);
    chk("mem5_full", mem[5], 32'hA1B2C3D4);
    do_write(10'd5, 32'h11223344, 4'b0101);
    chk("mem5_partial", mem[5], 32'hA122C344);
    do_write(10'd5, 32'hFFFFFFFF, 4'b0000);
    chk("mem5_clear", mem[5], 32'h0);
    golden[5] = 32'h0;

    // Same-address reader blocked for the whole write; other reader granted at once.
    bus.wr_valid = 1'b1; bus.wr_addr = 10'd7; bus.wr_data = 32'h0BADF00D; bus.wr_bmask = 4'hF;
    #2 chk("haz_accept", {31'b0, bus.wr_ready}, 1);
    @(negedge clk);
    bus.wr_valid = 1'b0;
    bus.rd_valid = 2'b11;
    bus.rd_addr  = {10'd8, 10'd7};
    #2;
    chk("haz_gnt_c1", {30'b0, bus.rd_gnt}, 2'b10);
    chk("haz_raddr_c1", {22'b0, sram_raddr}, 8);
    @(negedge clk);
    bus.rd_valid = 2'b01;
    #2;
    chk("haz_blocked", {30'b0, bus.rd_gnt}, 0);
    chk("haz_rvalid_c1", {30'b0, bus.rd_rvalid}, 2'b10);
    chk("haz_rdata_c1", bus.rd_rdata, golden[8]);
    @(negedge clk);
    #2 chk("haz_blocked", {30'b0, bus.rd_gnt}, 0);
    @(negedge clk);
    #2 chk("haz_blocked", {30'b0, bus.rd_gnt}, 0);
    @(negedge clk);
    #2;
    chk("haz_gnt_c0", {30'b0, bus.rd_gnt}, 2'b01);
    chk("haz_raddr_c0", {22'b0, sram_raddr}, 7);
    @(negedge clk);
    bus.rd_valid = 2'b00;
    #2;
    chk("haz_rvalid_c0", {30'b0, bus.rd_rvalid}, 2'b01);
    chk("haz_rdata_c0", bus.rd_rdata, 32'h0BADF00D);
    golden[7] = 32'h0BADF00D;
    @(negedge clk);
    drive_idle();

    // Reset after the second byte of a four-byte write.
    do_write(10'd9, 32'hDEADBEEF, 4'hF);
    bus.wr_valid = 1'b1; bus.wr_addr = 10'd9; bus.wr_data = 32'h55667788; bus.wr_bmask = 4'hF;
    #2 chk("srst_accept", {31'b0, bus.wr_ready}, 1);
    @(negedge clk);
    bus.wr_valid = 1'b0;
    #2 chk("srst_byte0", {28'b0, sram_bytemask}, 4'h1);
    @(negedge clk);
    #2 chk("srst_byte1", {28'b0, sram_bytemask}, 4'h2);
    @(negedge clk);
    srst = 1'b1;
    #2;
    chk("srst_wsb", {31'b0, sram_wsb}, 1);
    chk("srst_ready", {31'b0, bus.wr_ready}, 0);
    @(negedge clk);
    srst = 1'b0;
    #2 check_reset_values();
    chk("srst_mem9", mem[9], 32'hDEAD7788);
    golden[9] = 32'hDEAD7788;
    @(negedge clk);

    // Randomized phase against a transaction-level model.
    w_pend = 1'b0; w_addr = '0; w_data = '0; w_mask = '0;
    r_pend = 2'b00; r_addr[0] = '0; r_addr[1] = '0;
    busy_left = 0; b_addr = '0; b_data = '0; b_mask = '0;
    m_last = 1;
    prev_g = 2'b00;
    cyc = 0;
    while (1) begin
      if (cyc < 500) begin
        if (!w_pend && $urandom_range(0, 2) == 0) begin
          w_pend = 1'b1;
          w_addr = 10'($urandom_range(0, 7));
          w_data = $urandom;
          w_mask = 4'($urandom_range(0, 15));
        end
        for (int i = 0; i < 2; i++) begin
          if (!r_pend[i] && $urandom_range(0, 1) == 0) begin
            r_pend[i] = 1'b1;
            r_addr[i] = 10'($urandom_range(0, 7));
          end
        end
      end else if (!w_pend && r_pend == 2'b00 && busy_left == 0 && prev_g == 2'b00) begin
        break;
      end
      if (cyc >= 600) begin
        chk("rand_drain_timeout", cyc, 600);
        break;
      end
      bus.wr_valid = w_pend;
      bus.wr_addr  = w_addr;
      bus.wr_data  = w_data;
      bus.wr_bmask = w_mask;
      bus.rd_valid = r_pend;
      bus.rd_addr  = {r_addr[1], r_addr[0]};
      #2;
      exp_ready = (busy_left == 0);
      for (int i = 0; i < 2; i++)
        elig[i] = r_pend[i] && !(busy_left > 0 && r_addr[i] == b_addr);
      if (elig == 2'b11) exp_g = (m_last == 0) ? 2'b10 : 2'b01;
      else               exp_g = elig;
      chk("rand_ready", {31'b0, bus.wr_ready}, {31'b0, exp_ready});
      chk("rand_gnt", {30'b0, bus.rd_gnt}, {30'b0, exp_g});
      chk("rand_csb", {31'b0, sram_csb}, {31'b0, !(exp_g != 2'b00 || busy_left > 0)});
      chk("rand_wsb", {31'b0, sram_wsb}, {31'b0, busy_left == 0});
      chk("rand_rvalid", {30'b0, bus.rd_rvalid}, {30'b0, prev_g});
      if (prev_g != 2'b00) begin
        if (exp_q.size() == 0) chk("rand_expq_empty", 1, 0);
        else begin
          exp_d = exp_q.pop_front();
          chk("rand_rdata", bus.rd_rdata, exp_d);
        end
      end
      if (exp_g != 2'b00) begin
        idx = exp_g[1] ? 1 : 0;
        exp_q.push_back(golden[r_addr[idx][7:0]]);
        r_pend[idx] = 1'b0;
        m_last = idx;
      end
      prev_g = exp_g;
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) golden[b_addr[7:0]] = merge(golden[b_addr[7:0]], b_data, b_mask);
      end
      if (w_pend && exp_ready) begin
        b_addr = w_addr; b_data = w_data; b_mask = w_mask;
        busy_left = (w_mask == 4'b0000) ? 1 : $countones(w_mask);
        w_pend = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    drive_idle();
    @(negedge clk);
    for (int i = 0; i < 16; i++) chk("final_mem", mem[i], golden[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
